// File: rtl/pb_debounce_pkg.sv
// Shared types and helpers for the multi-channel pushbutton debouncer.
package pb_debounce_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_PRESSED,
    ST_HELD,
    ST_LONG,
    ST_AUTO,
    ST_REL_COUNT,
    ST_RELEASED
  } pb_state_e;

  // One timer serves every window, so it is sized by the largest of them.
  function automatic int tmr_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pb_debouncer_channel.sv
// One pushbutton channel: 2-FF synchronizer, debounce/hold/repeat FSM and timer.
module pb_debouncer_channel
  import pb_debounce_pkg::*;
#(
  parameter int DELAY         = 15,
  parameter int HOLD_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  input  logic repeat_en,
  output logic pressed_status,
  output logic pressed_pulse,
  output logic released_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int TW = tmr_w(DELAY, HOLD_DELAY, REPEAT_PERIOD);
  localparam logic [TW-1:0] D_END = TW'(DELAY - 1);
  localparam logic [TW-1:0] H_END = TW'(HOLD_DELAY - 1);
  localparam logic [TW-1:0] R_END = TW'(REPEAT_PERIOD - 1);

  logic [1:0]    sync_q;
  logic          s;
  pb_state_e     state, state_nxt;
  logic [TW-1:0] tmr;
  logic          tmr_inc, tmr_clr;
  logic          long_done;

  assign s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      state     <= ST_IDLE;
      tmr       <= '0;
      long_done <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pb};
      state  <= state_nxt;
      // Any state change restarts the shared timer.
      if (tmr_clr || (state_nxt != state)) tmr <= '0;
      else if (tmr_inc)                     tmr <= tmr + 1'b1;
      if (state == ST_LONG)          long_done <= 1'b1;
      else if (state == ST_RELEASED) long_done <= 1'b0;
    end
  end

  always_comb begin
    state_nxt      = state;
    tmr_inc        = 1'b0;
    tmr_clr        = 1'b0;
    pressed_status = 1'b0;
    pressed_pulse  = 1'b0;
    released_pulse = 1'b0;
    long_pulse     = 1'b0;
    repeat_pulse   = 1'b0;
    case (state)
      ST_IDLE: if (s) state_nxt = ST_COUNT;
      ST_COUNT: begin
        if (!s)               state_nxt = ST_IDLE;
        else if (tmr == D_END) state_nxt = ST_PRESSED;
        else                  tmr_inc   = 1'b1;
      end
      ST_PRESSED: begin
        pressed_pulse  = 1'b1;
        pressed_status = 1'b1;
        state_nxt      = ST_HELD;
      end
      ST_HELD: begin
        pressed_status = 1'b1;
        if (!s)               state_nxt = ST_REL_COUNT;
        else if (tmr == H_END) state_nxt = ST_LONG;
        else                  tmr_inc   = 1'b1;
      end
      ST_LONG: begin
        long_pulse     = 1'b1;
        pressed_status = 1'b1;
        state_nxt      = ST_AUTO;
      end
      ST_AUTO: begin
        pressed_status = 1'b1;
        repeat_pulse   = (tmr == R_END) && repeat_en;
        if (!s)               state_nxt = ST_REL_COUNT;
        else if (tmr == R_END) tmr_clr   = 1'b1;
        else                  tmr_inc   = 1'b1;
      end
      ST_REL_COUNT: begin
        pressed_status = 1'b1;
        // A bounce returns to the hold phase we came from, with no event.
        if (s)                state_nxt = long_done ? ST_AUTO : ST_HELD;
        else if (tmr == D_END) state_nxt = ST_RELEASED;
        else                  tmr_inc   = 1'b1;
      end
      ST_RELEASED: begin
        released_pulse = 1'b1;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/pb_debouncer_multi.sv
// N_CH independent pushbutton debouncers with press/release/long/auto-repeat events.
module pb_debouncer_multi
  import pb_debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DELAY         = 15,
  parameter int HOLD_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] pressed_status,
  output logic [N_CH-1:0] pressed_pulse,
  output logic [N_CH-1:0] released_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pb_debouncer_channel #(
      .DELAY         (DELAY),
      .HOLD_DELAY    (HOLD_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .pb             (pb[i]),
      .repeat_en      (repeat_en[i]),
      .pressed_status (pressed_status[i]),
      .pressed_pulse  (pressed_pulse[i]),
      .released_pulse (released_pulse[i]),
      .long_pulse     (long_pulse[i]),
      .repeat_pulse   (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_pb_debouncer_multi.sv
// Directed bench for pb_debouncer_multi with DELAY=4, HOLD_DELAY=20, REPEAT_PERIOD=8.
module tb_pb_debouncer_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pb, repeat_en;
  logic [3:0] pressed_status, pressed_pulse, released_pulse, long_pulse, repeat_pulse;

  int n_chk  = 0;
  int n_pass = 0;

  pb_debouncer_multi #(
    .N_CH(4), .DELAY(4), .HOLD_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pb             (pb),
    .repeat_en      (repeat_en),
    .pressed_status (pressed_status),
    .pressed_pulse  (pressed_pulse),
    .released_pulse (released_pulse),
    .long_pulse     (long_pulse),
    .repeat_pulse   (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // tick(n) after inputs change at time t: the n-th tick ends just after edge k+n-1,
  // where k is the first edge sampling the new inputs.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [19:0] all_out;
  assign all_out = {pressed_status, pressed_pulse, released_pulse, long_pulse, repeat_pulse};

  initial begin
    logic [3:0] acc, acc_st;
    int c2, c3;

    rst_n = 1'b0; pb = '0; repeat_en = '0;
    tick(3);
    chk("reset_outputs", 32'(all_out), 0);
    rst_n = 1'b1;
    tick(1);
    chk("idle_outputs", 32'(all_out), 0);

    // Single press on ch0: pulse after edge k+6
    pb = 4'b0001;
    tick(6);
    chk("ch0_press_early", 32'(pressed_pulse), 0);
    chk("ch0_status_early", 32'(pressed_status), 0);
    tick(1);
    chk("ch0_press", 32'(pressed_pulse), 'h1);
    chk("ch0_status", 32'(pressed_status), 'h1);
    chk("ch0_other_pulses", 32'({released_pulse, long_pulse, repeat_pulse}), 0);
    tick(1);
    chk("ch0_press_one_cycle", 32'(pressed_pulse), 0);
    chk("ch0_status_held", 32'(pressed_status), 'h1);

    // Release ch0 before long press: released after 7 ticks
    pb = 4'b0000;
    tick(6);
    chk("ch0_rel_early", 32'(released_pulse), 0);
    chk("ch0_status_relcount", 32'(pressed_status), 'h1);
    tick(1);
    chk("ch0_rel", 32'(released_pulse), 'h1);
    chk("ch0_status_off", 32'(pressed_status), 0);
    tick(1);
    chk("ch0_rel_one_cycle", 32'(released_pulse), 0);
    chk("ch0_no_long", 32'(long_pulse), 0);

    // Glitch on ch1 for 3 cycles: no events
    pb = 4'b0010;
    tick(3);
    pb = 4'b0000;
    acc = '0; acc_st = '0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      acc    |= pressed_pulse | released_pulse | long_pulse | repeat_pulse;
      acc_st |= pressed_status;
    end
    chk("ch1_glitch_pulses", 32'(acc), 0);
    chk("ch1_glitch_status", 32'(acc_st), 0);

    // Hold ch2 (repeat on) and ch3 (repeat off)
    pb = 4'b1100; repeat_en = 4'b0100;
    tick(27);
    chk("long_early", 32'(long_pulse), 0);
    chk("hold_status", 32'(pressed_status), 'hC);
    tick(1);
    chk("long_k27", 32'(long_pulse), 'hC);
    chk("long_status", 32'(pressed_status), 'hC);
    tick(7);
    chk("repeat_early", 32'(repeat_pulse), 0);
    tick(1);
    chk("repeat_k35", 32'(repeat_pulse), 'h4);
    chk("long_once", 32'(long_pulse), 0);
    tick(8);
    chk("repeat_k43", 32'(repeat_pulse), 'h4);
    repeat_en = 4'b0000;
    tick(8);
    chk("repeat_k51_suppressed", 32'(repeat_pulse), 0);
    repeat_en = 4'b0100;
    tick(8);
    chk("repeat_k59", 32'(repeat_pulse), 'h4);

    // 2-cycle bounce low on ch2 while in auto-repeat
    pb = 4'b1000;
    acc = '0; acc_st = 4'hF;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) pb = 4'b1100;
      tick(1);
      acc    |= released_pulse | pressed_pulse | long_pulse;
      acc_st &= pressed_status;
    end
    chk("bounce_no_event", 32'(acc), 0);
    chk("bounce_status_kept", 32'(acc_st), 'hC);

    // Real release of ch2 and ch3
    pb = 4'b0000;
    c2 = 0; c3 = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      c2 += int'(released_pulse[2]);
      c3 += int'(released_pulse[3]);
    end
    chk("ch2_one_release", 32'(c2), 1);
    chk("ch3_one_release", 32'(c3), 1);
    chk("all_released_status", 32'(pressed_status), 0);

    // All channels at once, then reset mid-hold
    pb = 4'b1111; repeat_en = 4'b0000;
    tick(6);
    chk("all_press_early", 32'(pressed_pulse), 0);
    tick(1);
    chk("all_press", 32'(pressed_pulse), 'hF);
    tick(8);
    chk("all_held", 32'(pressed_status), 'hF);
    rst_n = 1'b0;
    tick(1);
    chk("reset_mid_hold", 32'(all_out), 0);
    acc = '0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      acc |= released_pulse | pressed_status;
    end
    chk("reset_no_release", 32'(acc), 0);

    // Fresh debounce after reset with buttons still held
    rst_n = 1'b1;
    tick(6);
    chk("post_reset_early", 32'(all_out), 0);
    tick(1);
    chk("post_reset_press", 32'(pressed_pulse), 'hF);
    pb = 4'b0000;
    tick(12);
    chk("final_idle", 32'(pressed_status), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
